// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu: turns PS/2 mouse packets into saturating signed analog axes and fire buttons,
// yielding to a physical stick whenever one reports a non-zero value.
module mouse_axis_emu #(
   parameter int AXIS_W    = 8,
   parameter int DELTA_MAX = 10,
   parameter int DECAY_W   = 16
) (
   input  logic                     CLK_VIDEO,
   input  logic                     reset,
   input  logic [24:0]              ps2_mouse,
   input  logic [15:0]              joya,
   input  logic                     halt,
   input  logic                     invert_y,
   input  logic [1:0]               sens,
   input  logic                     mode,
   output logic                     active,
   output logic signed [AXIS_W-1:0] axis_x,
   output logic signed [AXIS_W-1:0] axis_y,
   output logic [1:0]               btn
);
   localparam int S = AXIS_W + 2;
   localparam logic signed [11:0]       DMAX = 12'(DELTA_MAX);
   localparam logic signed [S-1:0]      SMAX = S'(2 ** (AXIS_W - 1) - 1);
   localparam logic signed [S-1:0]      SMIN = -SMAX - S'(1);
   localparam logic signed [AXIS_W-1:0] ONE  = AXIS_W'(1);

   logic                     old_stb_q, old_stb_d;
   logic                     active_q, active_d;
   logic signed [AXIS_W-1:0] x_q, x_d, y_q, y_d;
   logic [1:0]               btn_q, btn_d;
   logic [DECAY_W-1:0]       cnt_q, cnt_d;
   logic                     pkt, ovr, tick;

   function automatic logic signed [11:0] delta(input logic s, input logic [7:0] b,
                                                input logic [1:0] sh, input logic neg);
      logic signed [11:0] raw, d;
      raw = {{4{s}}, b};
      d = (raw >>> 1) <<< sh;
      d = (d > DMAX) ? DMAX : (d < -DMAX) ? -DMAX : d;
      return neg ? -d : d;
   endfunction

   // widened sum cannot wrap, so a plain compare saturates it
   function automatic logic signed [AXIS_W-1:0] acc(input logic signed [AXIS_W-1:0] a,
                                                    input logic signed [11:0] d);
      logic signed [S-1:0] s;
      s = S'(a) + S'(d);
      s = (s > SMAX) ? SMAX : (s < SMIN) ? SMIN : s;
      return AXIS_W'(s);
   endfunction

   function automatic logic signed [AXIS_W-1:0] toward0(input logic signed [AXIS_W-1:0] a);
      return (a < 0) ? a + ONE : (a > 0) ? a - ONE : a;
   endfunction

   always_comb begin
      pkt       = ps2_mouse[24] != old_stb_q;
      ovr       = (|joya) || halt;
      tick      = mode && active_q && (&cnt_q);
      old_stb_d = ps2_mouse[24];
      active_d  = active_q;
      x_d       = x_q;
      y_d       = y_q;
      btn_d     = btn_q;
      cnt_d     = (mode && active_q) ? cnt_q + DECAY_W'(1) : '0;
      if (ovr) begin
         active_d = 1'b0;
         x_d      = '0;
         y_d      = '0;
         btn_d    = '0;
         cnt_d    = '0;
      end else if (pkt) begin
         active_d = 1'b1;
         x_d      = acc(x_q, delta(ps2_mouse[4], ps2_mouse[15:8], sens, 1'b0));
         y_d      = acc(y_q, delta(ps2_mouse[5], ps2_mouse[23:16], sens, invert_y));
         btn_d    = ps2_mouse[1:0];
      end else if (tick) begin
         x_d = toward0(x_q);
         y_d = toward0(y_q);
      end
   end

   always_ff @(posedge CLK_VIDEO) begin
      old_stb_q <= old_stb_d;
      if (reset) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         btn_q    <= '0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         btn_q    <= btn_d;
         cnt_q    <= cnt_d;
      end
   end

   assign active = active_q;
   assign axis_x = x_q;
   assign axis_y = y_q;
   assign btn    = btn_q;
endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb_mouse_axis_emu: directed scenarios plus randomized traffic against an integer reference model.
module tb_mouse_axis_emu;
   logic              CLK_VIDEO = 1'b0;
   logic              reset = 1'b1;
   logic [24:0]       ps2_mouse = '0;
   logic [15:0]       joya = '0;
   logic              halt = 1'b0, invert_y = 1'b0, mode = 1'b0;
   logic [1:0]        sens = '0;
   logic              active;
   logic signed [7:0] axis_x, axis_y;
   logic [1:0]        btn;
   int vec = 0, errs = 0;
   int m_act = 0, m_x = 0, m_y = 0, m_btn = 0, m_cnt = 0;
   bit m_old = 1'b0;

   mouse_axis_emu #(.AXIS_W(8), .DELTA_MAX(10), .DECAY_W(4)) dut (
      .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya), .halt(halt),
      .invert_y(invert_y), .sens(sens), .mode(mode), .active(active), .axis_x(axis_x),
      .axis_y(axis_y), .btn(btn));

   always #5 CLK_VIDEO = ~CLK_VIDEO;

   function automatic int mdelta(bit s, int b, int sh, bit neg);
      int r = s ? b - 256 : b;
      int d = (r >= 0 ? r / 2 : -((1 - r) / 2)) * (1 << sh);
      if (d > 10) d = 10;
      if (d < -10) d = -10;
      return neg ? -d : d;
   endfunction

   function automatic int sat(int v);
      return v > 127 ? 127 : v < -128 ? -128 : v;
   endfunction

   function automatic int shrink(int v);
      return v > 0 ? v - 1 : v < 0 ? v + 1 : 0;
   endfunction

   task automatic model_step();
      bit pk = ps2_mouse[24] != m_old;
      bit tk;
      if (reset || joya != 0 || halt) begin
         m_act = 0; m_x = 0; m_y = 0; m_btn = 0; m_cnt = 0;
      end else begin
         tk = mode && m_act != 0 && m_cnt == 15 && !pk;
         m_cnt = (mode && m_act != 0) ? (m_cnt + 1) % 16 : 0;
         if (pk) begin
            m_act = 1;
            m_x = sat(m_x + mdelta(ps2_mouse[4], int'(ps2_mouse[15:8]), int'(sens), 1'b0));
            m_y = sat(m_y + mdelta(ps2_mouse[5], int'(ps2_mouse[23:16]), int'(sens), invert_y));
            m_btn = int'(ps2_mouse[1:0]);
         end else if (tk) begin
            m_x = shrink(m_x);
            m_y = shrink(m_y);
         end
      end
      m_old = ps2_mouse[24];
   endtask

   task automatic cyc();
      model_step();
      @(posedge CLK_VIDEO);
      #1;
   endtask

   task automatic pkt(bit sx, bit [7:0] bx, bit sy, bit [7:0] by, bit [1:0] b);
      ps2_mouse[15:8] = bx; ps2_mouse[4] = sx;
      ps2_mouse[23:16] = by; ps2_mouse[5] = sy;
      ps2_mouse[1:0] = b;
      ps2_mouse[24] = ~ps2_mouse[24];
      cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1; cyc(); reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) cyc();
      reset = 1'b0;
      pkt(0, 8'h28, 0, 8'h00, 2'b11);
      reset = 1'b1; ps2_mouse[24] = 1'b1; ps2_mouse[15:8] = 8'h10;
      cyc();
      vec++; if ({active, axis_x, axis_y, btn} !== 19'd0) begin errs++; $display("FAIL reset_clear act=%b x=%0d y=%0d btn=%b want all 0", active, axis_x, axis_y, btn); end
      ps2_mouse[24] = ~ps2_mouse[24]; cyc();
      ps2_mouse[24] = 1'b1; cyc();
      reset = 1'b0;
      repeat (3) cyc();
      vec++; if ({active, axis_x, axis_y, btn} !== 19'd0) begin errs++; $display("FAIL reset_release act=%b x=%0d y=%0d want idle", active, axis_x, axis_y); end
   endtask

   task automatic test_basic();
      pkt(0, 8'h28, 0, 8'h00, 2'b00);
      vec++; if (axis_x !== 10 || axis_y !== 0 || active !== 1'b1) begin errs++; $display("FAIL basic x=%0d y=%0d act=%b want 10 0 1", axis_x, axis_y, active); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 14; i++) begin
         pkt(0, 8'h28, 0, 8'h00, 2'b00);
         vec++; if (axis_x !== m_x) begin errs++; $display("FAIL b2b_up[%0d] x=%0d want %0d", i, axis_x, m_x); end
      end
      vec++; if (axis_x !== 127) begin errs++; $display("FAIL sat_pos x=%0d want 127", axis_x); end
      for (int i = 0; i < 27; i++) pkt(1, 8'hD8, 0, 8'h00, 2'b00);
      vec++; if (axis_x !== -128) begin errs++; $display("FAIL sat_neg x=%0d want -128", axis_x); end
   endtask

   task automatic test_invert_sens();
      do_reset(); invert_y = 1'b1;
      pkt(0, 8'h00, 1, 8'hFA, 2'b00);
      vec++; if (axis_y !== 3) begin errs++; $display("FAIL invert_on y=%0d want 3", axis_y); end
      do_reset(); invert_y = 1'b0;
      pkt(0, 8'h00, 1, 8'hFA, 2'b00);
      vec++; if (axis_y !== -3) begin errs++; $display("FAIL invert_off y=%0d want -3", axis_y); end
      sens = 2'd2;
      pkt(0, 8'h04, 0, 8'h00, 2'b00);
      vec++; if (axis_x !== 8 || axis_y !== -3) begin errs++; $display("FAIL sens2 x=%0d y=%0d want 8 -3", axis_x, axis_y); end
      sens = 2'd0;
   endtask

   task automatic test_override();
      do_reset();
      for (int i = 0; i < 5; i++) pkt(0, 8'h28, i < 2, i < 2 ? 8'hD8 : 8'h00, i == 4 ? 2'b01 : 2'b00);
      vec++; if (axis_x !== 50 || axis_y !== -20 || btn !== 2'b01) begin errs++; $display("FAIL ovr_setup x=%0d y=%0d btn=%b want 50 -20 01", axis_x, axis_y, btn); end
      joya = 16'h0100;
      pkt(0, 8'h28, 0, 8'h00, 2'b11);
      vec++; if ({active, axis_x, axis_y, btn} !== 19'd0) begin errs++; $display("FAIL ovr_clear act=%b x=%0d y=%0d btn=%b want 0", active, axis_x, axis_y, btn); end
      joya = '0; cyc();
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL ovr_release act=%b want 0", active); end
      pkt(0, 8'h02, 0, 8'h00, 2'b00);
      vec++; if (axis_x !== 1 || active !== 1'b1) begin errs++; $display("FAIL ovr_resume x=%0d act=%b want 1 1", axis_x, active); end
      halt = 1'b1; cyc(); halt = 1'b0;
      vec++; if (active !== 1'b0 || axis_x !== 0) begin errs++; $display("FAIL halt act=%b x=%0d want 0 0", active, axis_x); end
   endtask

   task automatic test_decay();
      do_reset(); mode = 1'b0;
      pkt(0, 8'h0A, 1, 8'hFC, 2'b00);
      mode = 1'b1;
      repeat (16) cyc();
      vec++; if (axis_x !== 4 || axis_y !== -1) begin errs++; $display("FAIL decay16 x=%0d y=%0d want 4 -1", axis_x, axis_y); end
      repeat (16) cyc();
      vec++; if (axis_x !== 3 || axis_y !== 0) begin errs++; $display("FAIL decay32 x=%0d y=%0d want 3 0", axis_x, axis_y); end
      repeat (48) cyc();
      vec++; if (axis_x !== 0 || axis_y !== 0) begin errs++; $display("FAIL decay80 x=%0d y=%0d want 0 0", axis_x, axis_y); end
      repeat (20) cyc();
      vec++; if (axis_x !== 0 || axis_y !== 0 || active !== 1'b1) begin errs++; $display("FAIL decay_hold x=%0d y=%0d act=%b want 0 0 1", axis_x, axis_y, active); end
      do_reset(); mode = 1'b0;
      pkt(0, 8'h14, 0, 8'h00, 2'b00);
      mode = 1'b1;
      repeat (15) cyc();
      pkt(0, 8'h04, 0, 8'h00, 2'b00);
      vec++; if (axis_x !== 12) begin errs++; $display("FAIL decay_collide x=%0d want 12", axis_x); end
      repeat (16) cyc();
      vec++; if (axis_x !== 11) begin errs++; $display("FAIL decay_wrap x=%0d want 11", axis_x); end
      mode = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            ps2_mouse[23:0] = 24'($urandom);
            ps2_mouse[24] = ~ps2_mouse[24];
         end
         sens = 2'($urandom_range(0, 3));
         invert_y = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         joya = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
         halt = $urandom_range(0, 39) == 0;
         reset = $urandom_range(0, 59) == 0;
         cyc();
         vec++; if (active !== m_act[0] || axis_x !== m_x || axis_y !== m_y || btn !== m_btn[1:0]) begin
            errs++; $display("FAIL rand[%0d] act=%b x=%0d y=%0d btn=%b want %0d %0d %0d %0d", i, active, axis_x, axis_y, btn, m_act, m_x, m_y, m_btn);
         end
      end
      reset = 1'b0; halt = 1'b0; joya = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_invert_sens();
      test_override();
      test_decay();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/mouse_axis_emu.md
# mouse_axis_emu

Parametrised mouse-to-analog-stick emulator for the console cores. Converts PS/2 mouse movement packets from hps_io into saturating signed analog axis values plus two fire buttons. It sits between hps_io and the core's analog joystick inputs, with these features:
- configurable axis width and per-packet delta clamp;
- Y inversion;
- sensitivity scaling;
- optional self-centering decay mode.

Emulation hands back to a real analog stick automatically whenever that stick reports a non-zero value.

## Interface
Parameters:
- AXIS_W, 8: axis output width in bits (signed), range 4..12.
- DELTA_MAX, 10: maximum absolute per-packet delta after scaling; must be less than 2^(AXIS_W-1).
- DECAY_W, 16: width of the decay period counter; period is 2^DECAY_W cycles.

Ports:
- CLK_VIDEO, in, 1: clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- ps2_mouse, in, 25: hps_io mouse word.
  - [24] is the packet toggle strobe.
  - [15:8] is the dx byte and [4] is the dx sign.
  - [23:16] is the dy byte and [5] is the dy sign.
  - [1:0] are the buttons.
- joya, in, 16: physical analog stick {y[7:0], x[7:0]}. Any non-zero value means a physical stick is present.
- halt, in, 1: core halted or OSD busy. Forces emulation off.
- invert_y, in, 1: when 1, the Y delta is subtracted instead of added.
- sens, in, 2: sensitivity, applied as a left shift of 0..3 bits.
- mode, in, 1: 0 = accumulate, 1 = accumulate with self-centering decay.
- active, out, 1: emulation owns the axes. The core must mux axis_x/axis_y/btn in place of the physical stick only while active = 1.
- axis_x, out, AXIS_W: signed X position.
- axis_y, out, AXIS_W: signed Y position.
- btn, out, 2: fire buttons {right, left}.

## Operation
- Packet detect: old_stb registers ps2_mouse[24] every cycle, including during reset and override. A packet is present in a cycle when ps2_mouse[24] != old_stb.
- Per-axis delta arithmetic, in 12-bit signed:
  - raw = {sign, byte}, sign-extended.
  - d = (raw >>> 1) <<< sens.
  - d is clamped to [-DELTA_MAX, +DELTA_MAX].
  - For Y with invert_y = 1, d is negated after clamping.
- Accumulate: new = acc + d, computed at AXIS_W+2 bits, then saturated to [-2^(AXIS_W-1), 2^(AXIS_W-1)-1]. Values never wrap.
- On a packet: active <= 1, both axes update, and btn <= ps2_mouse[1:0].
- Decay, only when mode = 1 and active = 1:
  - The counter increments every cycle.
  - At all-ones, each non-zero axis moves 1 toward 0. Zero stays zero.
  - With mode = 0 or active = 0, the counter is held at 0.
- Per-cycle priority, highest first:
  1. reset
  2. override (joya != 0 or halt)
  3. packet
  4. decay
  
  A packet and a decay tick in the same cycle: the packet is applied, the decay step is skipped, and the counter still wraps.
- Override: active <= 0, axes <= 0, btn <= 0, decay counter <= 0. A packet arriving during override is discarded, not queued.
- Reset values: active 0, axis_x 0, axis_y 0, btn 0, decay counter 0. old_stb loads the current ps2_mouse[24] so that no spurious packet is seen on release.

## Timing
- All outputs are registered. A packet sampled at edge k is visible on the outputs after edge k, i.e. 1-cycle latency.
- Override asserted at edge k clears the outputs after edge k. Release takes effect on the next packet.
- Back-to-back packets (toggle on consecutive cycles) are each applied, one per cycle.
- Decay step interval is exactly 2^DECAY_W cycles from the counter leaving 0.
- Reset asserted mid-operation clears state at the next edge regardless of pending packet or decay.

## Test plan
- Defaults, sens=0: packet with dx byte 0x28 (sign 0) -> next cycle axis_x=10 (clamped from 20), axis_y=0, active=1.
- 13 packets of dx=+40 -> axis_x saturates at 127 and stays at 127 on a 14th packet. Mirror with sign 1, byte 0xD8 -> axis_x saturates at -128.
- dy sign 1, byte 0xFA (-6) with invert_y=1 -> axis_y=+3; with invert_y=0 -> axis_y=-3. sens=2 with dx byte 0x04 -> axis_x=+8.
- While active with axes (50,-20) and btn=2'b01: joya=16'h0100 applied in the same cycle as a packet -> next cycle active=0, axes 0, btn 0, packet discarded. Clear joya, then send a packet dx=+2 -> axis_x=1.
- mode=1, DECAY_W=4, axis_x=5, axis_y=-2:
  - after 16 cycles -> (4,-1);
  - after 32 cycles -> (3,0);
  - after 80 cycles -> (0,0), held.
  
  A packet on a decay tick cycle -> the delta is applied with no decay step.
- Reset asserted while ps2_mouse[24]=1 and packets are pending -> all outputs 0. After release with [24] steady -> no update until the next toggle.
